// File: rtl/bumpy_mover_if.sv
// bumpy_mover_if: frame tick, FSM state and hit inputs plus position/visibility outputs for Bumpy
interface bumpy_mover_if;
  logic              startOfFrame;
  logic [3:0]        state;
  logic              land_hit;
  logic              ceil_hit;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic              visible;
  logic              death_done;
  modport master (
    output startOfFrame, state, land_hit, ceil_hit,
    input  topLeftX, topLeftY, visible, death_done
  );
  modport slave (
    input  startOfFrame, state, land_hit, ceil_hit,
    output topLeftX, topLeftY, visible, death_done
  );
endinterface

// File: rtl/bumpy_mover.sv
// bumpy_mover: per-frame Bumpy position physics (walk, jump, gravity, stops) and death blink
module bumpy_mover #(
  parameter int FP_SHIFT     = 6,
  parameter int INIT_X       = 300,
  parameter int INIT_Y       = 50,
  parameter int X_SPEED      = 64,
  parameter int JUMP_SPEED   = 320,
  parameter int GRAVITY      = 16,
  parameter int MAX_FALL     = 384,
  parameter int X_MAX        = 608,
  parameter int BLINK_FRAMES = 8,
  parameter int DIE_BLINKS   = 6
) (
  input  logic          clk,
  input  logic          resetN,
  bumpy_mover_if.slave  bus
);
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_IDLE  = 4'd1,
    S_LEFT  = 4'd2,
    S_RIGHT = 4'd3,
    S_DOWN  = 4'd4,
    S_UP    = 4'd5,
    S_DIE   = 4'd6
  } state_e;

  localparam int FW     = $clog2(BLINK_FRAMES + 1);
  localparam int TW     = $clog2(DIE_BLINKS + 1);
  localparam int X_INIT = INIT_X << FP_SHIFT;
  localparam int Y_INIT = INIT_Y << FP_SHIFT;
  localparam int X_LIM  = X_MAX << FP_SHIFT;

  logic signed [31:0] pos_x_q, pos_x_d;
  logic signed [31:0] pos_y_q, pos_y_d;
  logic signed [31:0] speed_y_q, speed_y_d;
  logic               land_q, land_d;
  logic               ceil_q, ceil_d;
  logic               jump_q, jump_d;
  logic [3:0]         prev_state_q, prev_state_d;
  logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]      toggle_cnt_q, toggle_cnt_d;
  logic               visible_q, visible_d;
  logic               death_done_q, death_done_d;

  logic               tick, land_any, ceil_any, jump_any, frame_wrap;
  logic signed [31:0] speed_grav, speed_new, x_step, x_clamp;
  logic [TW-1:0]      toggles_next;

  // Hit and jump-entry capture, and the candidate speed/position for a moving-state tick.
  // A hit or entry seen in the tick cycle itself already counts toward that update.
  always_comb begin
    tick         = bus.startOfFrame;
    land_any     = land_q | bus.land_hit;
    ceil_any     = ceil_q | bus.ceil_hit;
    jump_any     = jump_q | (bus.state == S_UP && prev_state_q != S_UP);
    speed_grav   = speed_y_q + GRAVITY;
    speed_new    = jump_any                     ? -32'(JUMP_SPEED) :
                   (land_any && !speed_y_q[31]) ? '0 :
                   (ceil_any &&  speed_y_q[31]) ? '0 :
                   (speed_grav > MAX_FALL)      ? 32'(MAX_FALL) : speed_grav;
    x_step       = (bus.state == S_LEFT)  ? pos_x_q - X_SPEED :
                   (bus.state == S_RIGHT) ? pos_x_q + X_SPEED : pos_x_q;
    x_clamp      = (x_step < 0) ? '0 : (x_step > X_LIM) ? 32'(X_LIM) : x_step;
    frame_wrap   = frame_cnt_q == FW'(BLINK_FRAMES - 1);
    toggles_next = toggle_cnt_q + 1'b1;
  end

  // Next-state selection: latches clear on every tick, movement only on ticks.
  always_comb begin
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    speed_y_d    = speed_y_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    visible_d    = visible_q;
    death_done_d = death_done_q;
    prev_state_d = bus.state;
    land_d       = tick ? 1'b0 : land_any;
    ceil_d       = tick ? 1'b0 : ceil_any;
    jump_d       = tick ? 1'b0 : jump_any;
    if (tick) begin
      case (bus.state)
        S_RESET: begin
          pos_x_d      = X_INIT;
          pos_y_d      = Y_INIT;
          speed_y_d    = '0;
          frame_cnt_d  = '0;
          toggle_cnt_d = '0;
          visible_d    = 1'b1;
          death_done_d = 1'b0;
        end
        S_LEFT, S_RIGHT, S_DOWN, S_UP: begin
          speed_y_d = speed_new;
          pos_y_d   = pos_y_q + speed_new;
          pos_x_d   = x_clamp;
        end
        S_DIE: begin
          if (!death_done_q) begin
            frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
            if (frame_wrap) begin
              toggle_cnt_d = toggles_next;
              visible_d    = (toggles_next == TW'(DIE_BLINKS)) ? 1'b0 : ~visible_q;
              death_done_d = toggles_next == TW'(DIE_BLINKS);
            end
          end
        end
        default: speed_y_d = '0;
      endcase
    end
  end

  // State registers with asynchronous reset to the start position.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x_q      <= X_INIT;
      pos_y_q      <= Y_INIT;
      speed_y_q    <= '0;
      land_q       <= 1'b0;
      ceil_q       <= 1'b0;
      jump_q       <= 1'b0;
      prev_state_q <= '0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      visible_q    <= 1'b1;
      death_done_q <= 1'b0;
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      speed_y_q    <= speed_y_d;
      land_q       <= land_d;
      ceil_q       <= ceil_d;
      jump_q       <= jump_d;
      prev_state_q <= prev_state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      visible_q    <= visible_d;
      death_done_q <= death_done_d;
    end
  end

  assign bus.topLeftX   = pos_x_q[FP_SHIFT +: 11];
  assign bus.topLeftY   = pos_y_q[FP_SHIFT +: 11];
  assign bus.visible    = visible_q;
  assign bus.death_done = death_done_q;
endmodule

// File: tb/tb_bumpy_mover.sv
// tb_bumpy_mover: directed frames against a frame-level physics model plus literal pins
module tb_bumpy_mover;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  bumpy_mover_if bif();
  bumpy_mover dut (.clk(clk), .resetN(resetN), .bus(bif));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int mx = 300 * 64;
  int my = 50 * 64;
  int msp = 0;
  int mfc = 0;
  int mtc = 0;
  bit mvis = 1'b1;
  bit mdone = 1'b0;
  bit mjump = 1'b0;
  int prev_drv = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick(input int st, input bit lh, input bit ch);
    if (st == 0) begin
      mx = 300 * 64; my = 50 * 64; msp = 0; mfc = 0; mtc = 0; mvis = 1; mdone = 0;
    end else if (st == 6) begin
      if (!mdone) begin
        mfc++;
        if (mfc == 8) begin
          mfc = 0; mtc++; mvis = !mvis;
          if (mtc == 6) begin mvis = 0; mdone = 1; end
        end
      end
    end else if (st >= 2 && st <= 5) begin
      if (mjump) msp = -320;
      else if (lh && msp >= 0) msp = 0;
      else if (ch && msp < 0) msp = 0;
      else msp = (msp + 16 > 384) ? 384 : msp + 16;
      my += msp;
      if (st == 2) mx -= 64;
      if (st == 3) mx += 64;
      if (mx < 0) mx = 0;
      if (mx > 608 * 64) mx = 608 * 64;
    end else msp = 0;
    mjump = 0;
  endtask

  // One frame: state set at cycle 0, optional hit at cycle hc, tick at cycle 3,
  // model advanced in cycle 4 once the DUT has registered the tick.
  task automatic run_frame(input int st, input bit lh, input bit ch, input int hc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 4) model_tick(st, lh, ch);
      bif.state = 4'(st);
      bif.land_hit = lh && i == hc;
      bif.ceil_hit = ch && i == hc;
      bif.startOfFrame = i == 3;
      if (i == 0 && st == 5 && prev_drv != 5) mjump = 1;
      prev_drv = st;
    end
  endtask

  task automatic run_n(input int n, input int st, input bit lh, input bit ch);
    for (int k = 0; k < n; k++) run_frame(st, lh, ch, 2);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("topLeftX", int'(bif.topLeftX), mx >>> 6);
      cmp("topLeftY", int'(bif.topLeftY), my >>> 6);
      cmp("visible", int'(bif.visible), int'(mvis));
      cmp("death_done", int'(bif.death_done), int'(mdone));
    end
  end

  initial begin
    bif.startOfFrame = 1'b0;
    bif.state = 4'd0;
    bif.land_hit = 1'b0;
    bif.ceil_hit = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;
    cmp("reset_x", int'(bif.topLeftX), 300);
    cmp("reset_y", int'(bif.topLeftY), 50);
    cmp("reset_vis", int'(bif.visible), 1);
    cmp("reset_done", int'(bif.death_done), 0);
    chk_en = 1'b1;
    run_n(3, 0, 0, 0);
    cmp("sreset_x", int'(bif.topLeftX), 300);
    cmp("sreset_y", int'(bif.topLeftY), 50);
    run_n(10, 3, 1, 0);
    cmp("walk_x", int'(bif.topLeftX), 310);
    cmp("walk_y", int'(bif.topLeftY), 50);
    run_n(1, 1, 0, 0);
    run_n(1, 5, 0, 0);
    cmp("jump1_y", int'(bif.topLeftY), 45);
    run_n(1, 5, 0, 0);
    cmp("jump2_y", int'(bif.topLeftY), 40);
    run_n(1, 5, 0, 0);
    cmp("jump3_y", int'(bif.topLeftY), 35);
    run_n(17, 5, 0, 0);
    cmp("peak_y", int'(bif.topLeftY), -3);
    run_n(30, 5, 0, 0);
    run_n(1, 9, 0, 0);
    run_frame(4, 1, 0, 3);
    run_frame(4, 1, 0, 3);
    run_n(1, 0, 0, 0);
    run_n(1, 1, 0, 0);
    run_n(2, 5, 0, 0);
    run_n(1, 5, 0, 1);
    cmp("ceil_stop_y", int'(bif.topLeftY), 40);
    run_n(2, 5, 0, 0);
    cmp("after_ceil_y", int'(bif.topLeftY), 41);
    run_n(2, 4, 1, 0);
    run_n(298, 2, 1, 0);
    cmp("left_to_2", int'(bif.topLeftX), 2);
    run_n(1, 2, 1, 0);
    cmp("left_1", int'(bif.topLeftX), 1);
    run_n(1, 2, 1, 0);
    cmp("left_0", int'(bif.topLeftX), 0);
    run_n(3, 2, 1, 0);
    cmp("left_clamp", int'(bif.topLeftX), 0);
    run_n(607, 3, 1, 0);
    cmp("right_607", int'(bif.topLeftX), 607);
    run_n(1, 3, 1, 0);
    cmp("right_608", int'(bif.topLeftX), 608);
    run_n(2, 3, 1, 0);
    cmp("right_clamp", int'(bif.topLeftX), 608);
    run_n(7, 6, 0, 0);
    cmp("die7_vis", int'(bif.visible), 1);
    run_n(1, 6, 0, 0);
    cmp("die8_vis", int'(bif.visible), 0);
    run_n(40, 6, 0, 0);
    cmp("die48_vis", int'(bif.visible), 0);
    cmp("die48_done", int'(bif.death_done), 1);
    run_n(3, 6, 0, 0);
    cmp("die_hold", int'(bif.death_done), 1);
    run_n(1, 0, 0, 0);
    cmp("reinit_done", int'(bif.death_done), 0);
    cmp("reinit_vis", int'(bif.visible), 1);
    cmp("reinit_x", int'(bif.topLeftX), 300);
    cmp("reinit_y", int'(bif.topLeftY), 50);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
